// File: rtl/rock_pkg.sv
// Shared types and constants for the rock controller / driver command interface.
package rock_pkg;

    localparam int unsigned AMP_W  = 3;
    localparam int unsigned FREQ_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        DEAD_F,
        REV,
        DEAD_R
    } rock_state_t;

    // Half-swing length in ticks; higher freq codes give shorter swings.
    function automatic int unsigned half_len(input int unsigned base,
                                             input logic [FREQ_W-1:0] f);
        return base * (32'd8 - 32'(f));
    endfunction

endpackage

// File: rtl/rock_pwm.sv
// Free-running PWM counter and duty compare for the cradle H-bridge.
module rock_pwm #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + PWM_BITS'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Compared against the count the next cycle holds, so the caller can register it.
    assign pwm = (cnt_d < duty);

endmodule

// File: rtl/rock_driver.sv
// Actuator end of the rock command interface: amp/freq codes to a swinging H-bridge drive.
// Optional soft start (amplitude ramp) is enabled by defining ROCK_SOFT_START_EN.
module rock_driver
    import rock_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned HALF_BASE  = 16,
    parameter int unsigned DEAD_TICKS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [AMP_W-1:0]  amp,
    input  logic [FREQ_W-1:0] freq,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              dir,
    output logic              busy,
    output logic              swing_done
);

    localparam int unsigned CntMax = (7 * HALF_BASE > DEAD_TICKS) ? 7 * HALF_BASE : DEAD_TICKS;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_TICKS - 1);

    rock_state_t       state_q, state_d;
    logic [CntW-1:0]   half_cnt_q, half_cnt_d;
    logic [AMP_W-1:0]  amp_l_q, amp_l_d;
    logic [FREQ_W-1:0] freq_l_q, freq_l_d;
    logic              done_d;
    logic [CntW-1:0]   half_last;
    logic [AMP_W-1:0]  amp_e_d;
    logic [PWM_BITS-1:0] duty;
    logic              pwm;

`ifdef ROCK_SOFT_START_EN
    logic [AMP_W-1:0]  amp_e_q;
`else
    assign amp_e_d = amp_l_d;
`endif

    assign half_last = CntW'(half_len(HALF_BASE, freq_l_q) - 32'd1);

    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        amp_l_d    = amp_l_q;
        freq_l_d   = freq_l_q;
        done_d     = 1'b0;
`ifdef ROCK_SOFT_START_EN
        amp_e_d    = amp_e_q;
`endif
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (amp != '0 && freq != '0) begin
                        state_d    = FWD;
                        amp_l_d    = amp;
                        freq_l_d   = freq;
                        half_cnt_d = '0;
`ifdef ROCK_SOFT_START_EN
                        amp_e_d    = AMP_W'(1);
`endif
                    end
                end
                FWD, REV: begin
                    if (half_cnt_q == half_last) begin
                        state_d    = (state_q == FWD) ? DEAD_F : DEAD_R;
                        done_d     = 1'b1;
                        amp_l_d    = amp;
                        freq_l_d   = freq;
                        half_cnt_d = '0;
`ifdef ROCK_SOFT_START_EN
                        // Stop requests skip the ramp and the dead time entirely.
                        if (amp == '0) begin
                            state_d = IDLE;
                            amp_e_d = '0;
                        end else if (amp > amp_e_q) begin
                            amp_e_d = amp_e_q + AMP_W'(1);
                        end else if (amp < amp_e_q) begin
                            amp_e_d = amp_e_q - AMP_W'(1);
                        end
`endif
                    end else begin
                        half_cnt_d = half_cnt_q + CntW'(1);
                    end
                end
                DEAD_F, DEAD_R: begin
                    if (half_cnt_q == DeadLast) begin
                        half_cnt_d = '0;
                        if (amp_l_q == '0 || freq_l_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = (state_q == DEAD_F) ? REV : FWD;
                        end
                    end else begin
                        half_cnt_d = half_cnt_q + CntW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Duty tracks the next-cycle amplitude so leg and duty change on the same edge.
    assign duty = PWM_BITS'(amp_e_d) << (PWM_BITS - 3);

    rock_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk   (clk),
        .reset (reset),
        .duty  (duty),
        .pwm   (pwm)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            amp_l_q    <= '0;
            freq_l_q   <= '0;
            pwm_a      <= 1'b0;
            pwm_b      <= 1'b0;
            dir        <= 1'b0;
            busy       <= 1'b0;
            swing_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            amp_l_q    <= amp_l_d;
            freq_l_q   <= freq_l_d;
            pwm_a      <= (state_d == FWD) && pwm;
            pwm_b      <= (state_d == REV) && pwm;
            dir        <= (state_d == FWD);
            busy       <= (state_d != IDLE);
            swing_done <= done_d;
        end
    end

`ifdef ROCK_SOFT_START_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            amp_e_q <= '0;
        end else begin
            amp_e_q <= amp_e_d;
        end
    end
`endif

endmodule
